// File: rtl/display_hex_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_hex_capture: recovers bytes from a 3-digit muxed 7-segment bus.  |
// | Optional macro DISPLAY_CAPTURE_SYNC_EN adds a 2-flop input synchronizer. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module display_hex_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] segments,
  input  logic [2:0] segments_enable,
  output logic [7:0] hex_byte,
  output logic       byte_valid,
  output logic       byte_strobe,
  output logic       decode_error
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (STALE_CYCLES < 2) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] C_SETTLE = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] C_STALE  = TW'(STALE_CYCLES);
  localparam logic [10:0]   C_MARKER = {3'b001, 8'h2E};

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    MARKED    = 2'd1,
    HAVE_HIGH = 2'd2
  } state_t;

  logic [10:0] sample_in;

`ifdef DISPLAY_CAPTURE_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {segments_enable, segments};
      sync2_q <= sync1_q;
    end
  end

  assign sample_in = sync2_q;
`else
  assign sample_in = {segments_enable, segments};
`endif

  // {valid, nibble} for a 7-segment digit glyph with DP clear
  function automatic logic [4:0] digit_decode(input logic [7:0] seg);
    case (seg)
      8'hFC: digit_decode = 5'h10;
      8'h60: digit_decode = 5'h11;
      8'hDA: digit_decode = 5'h12;
      8'hF2: digit_decode = 5'h13;
      8'h66: digit_decode = 5'h14;
      8'hB6: digit_decode = 5'h15;
      8'hBE: digit_decode = 5'h16;
      8'hE0: digit_decode = 5'h17;
      8'hFE: digit_decode = 5'h18;
      8'hF6: digit_decode = 5'h19;
      8'hEE: digit_decode = 5'h1A;
      8'h3E: digit_decode = 5'h1B;
      8'h9C: digit_decode = 5'h1C;
      8'h7A: digit_decode = 5'h1D;
      8'h9E: digit_decode = 5'h1E;
      8'h8E: digit_decode = 5'h1F;
      default: digit_decode = 5'h00;
    endcase
  endfunction

  logic [10:0]   s_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] stale_q, stale_d;
  state_t        state_q, state_d;
  logic [3:0]    hi_q, hi_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          strobe_q, error_q;
  logic          accept, commit, err;
  logic [4:0]    dig;
  logic          is_marker, is_high, is_low, is_blank, is_valid;

  // Acceptance fires on the edge the counter reaches SETTLE_CYCLES; s_q equals the input then
  always_comb begin
    settle_d = settle_q;
    accept   = 1'b0;
    if (sample_in != s_q) begin
      settle_d = '0;
    end else if (settle_q != C_SETTLE) begin
      settle_d = settle_q + SW'(1);
      accept   = (settle_d == C_SETTLE);
    end
  end

  assign dig       = digit_decode(s_q[7:0]);
  assign is_marker = (s_q == C_MARKER);
  assign is_high   = (s_q[10:8] == 3'b100) && dig[4];
  assign is_low    = (s_q[10:8] == 3'b010) && dig[4];
  assign is_blank  = (s_q[10:8] == 3'b000);
  assign is_valid  = is_marker | is_high | is_low;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    commit  = 1'b0;
    err     = 1'b0;
    if (accept && !is_blank) begin
      case (state_q)
        HUNT: begin
          if (is_marker) state_d = MARKED;
          else if (!is_valid) err = 1'b1;
        end
        MARKED: begin
          if (is_high) begin
            hi_d    = dig[3:0];
            state_d = HAVE_HIGH;
          end else if (!is_marker) begin
            state_d = HUNT;
            err     = 1'b1;
          end
        end
        HAVE_HIGH: begin
          err     = !is_low;
          commit  = is_low;
          state_d = is_marker ? MARKED : HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A commit wins over a simultaneous stale expiry
  always_comb begin
    stale_d = stale_q;
    valid_d = valid_q;
    byte_d  = byte_q;
    if (commit) begin
      stale_d = '0;
      valid_d = 1'b1;
      byte_d  = {hi_q, dig[3:0]};
    end else if (STALE_CYCLES != 0 && stale_q != C_STALE) begin
      stale_d = stale_q + TW'(1);
      if (stale_d == C_STALE) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      settle_q <= '0;
      stale_q  <= '0;
      state_q  <= HUNT;
      hi_q     <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      s_q      <= sample_in;
      settle_q <= settle_d;
      stale_q  <= stale_d;
      state_q  <= state_d;
      hi_q     <= hi_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      strobe_q <= commit;
      error_q  <= err;
    end
  end

  assign hex_byte     = byte_q;
  assign byte_valid   = valid_q;
  assign byte_strobe  = strobe_q;
  assign decode_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_display_hex_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_hex_capture: scoreboard bench with a slot-level reference.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_display_hex_capture;

  localparam int SETTLE = 16;
  localparam int STALE  = 200;
`ifdef DISPLAY_CAPTURE_SYNC_EN
  localparam int LAT = SETTLE + 3;
`else
  localparam int LAT = SETTLE + 1;
`endif
  localparam logic [7:0]  DIG [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                       8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  localparam logic [10:0] MK = {3'b001, 8'h2E};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] segments = '0;
  logic [2:0] segments_enable = '0;
  logic [7:0] hex_byte;
  logic       byte_valid, byte_strobe, decode_error;

  display_hex_capture #(.SETTLE_CYCLES(SETTLE), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst_n(rst_n), .segments(segments), .segments_enable(segments_enable),
    .hex_byte(hex_byte), .byte_valid(byte_valid), .byte_strobe(byte_strobe),
    .decode_error(decode_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    bit         commit;
    logic [7:0] val;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         e;
  int          vectors = 0;
  int          fails = 0;
  bit          m_mark = 0;
  int          m_hi = -1;
  logic [10:0] prev_run = '0;
  bit          m_valid = 0;
  logic [7:0]  m_byte = '0;
  int          m_last = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic int digit_of(input logic [7:0] seg);
    for (int i = 0; i < 16; i++) if (DIG[i] == seg) return i;
    return -1;
  endfunction

  function automatic logic [10:0] hi_slot(input int n);
    return {3'b100, DIG[n]};
  endfunction

  function automatic logic [10:0] lo_slot(input int n);
    return {3'b010, DIG[n]};
  endfunction

  // Reference frame rules applied to one accepted slot
  task automatic model_slot(input logic [10:0] v, input int stamp);
    logic [2:0] en;
    int         d;
    bit         mark, hi, lo;
    en   = v[10:8];
    d    = digit_of(v[7:0]);
    mark = (v == MK);
    hi   = (en == 3'b100) && (d >= 0);
    lo   = (en == 3'b010) && (d >= 0);
    if (en == 3'b000) return;
    if (m_hi >= 0) begin
      if (lo) exp_q.push_back('{stamp, 1'b1, {m_hi[3:0], d[3:0]}});
      else exp_q.push_back('{stamp, 1'b0, 8'h00});
      m_hi   = -1;
      m_mark = mark;
    end else if (m_mark) begin
      if (hi) m_hi = d;
      else if (!mark) begin
        exp_q.push_back('{stamp, 1'b0, 8'h00});
        m_mark = 0;
      end
    end else if (!(mark || hi || lo)) begin
      exp_q.push_back('{stamp, 1'b0, 8'h00});
    end else if (mark) begin
      m_mark = 1;
    end
  endtask

  // Called on a negedge; holds value v for d cycles
  task automatic slot(input logic [10:0] v, input int d);
    segments_enable = v[10:8];
    segments        = v[7:0];
    if (v != prev_run && d >= SETTLE + 1) model_slot(v, cyc + LAT);
    prev_run = v;
    repeat (d) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    segments_enable = '0;
    segments        = '0;
    #1;
    chk("rst_hex_byte", hex_byte, 8'h00);
    chk("rst_byte_valid", byte_valid, 8'h00);
    chk("rst_byte_strobe", byte_strobe, 8'h00);
    chk("rst_decode_error", decode_error, 8'h00);
    exp_q.delete();
    m_mark   = 0;
    m_hi     = -1;
    prev_run = '0;
    m_valid  = 0;
    m_byte   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        vectors++;
        fails++;
        $display("FAIL missed_event cyc=%0d got=none want=stamp %0d", cyc, exp_q[0].stamp);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
        e = exp_q.pop_front();
        if (e.commit) begin
          m_valid = 1;
          m_byte  = e.val;
          m_last  = cyc;
        end
        chk("byte_strobe", byte_strobe, e.commit);
        chk("decode_error", decode_error, !e.commit);
      end else begin
        chk("idle_strobe", byte_strobe, 8'h00);
        chk("idle_error", decode_error, 8'h00);
      end
      if (m_valid && (cyc - m_last) >= STALE) m_valid = 0;
      chk("byte_valid", byte_valid, m_valid);
      chk("hex_byte", hex_byte, m_byte);
    end
  end

  initial begin
    logic [10:0] v;
    int          r, d;
    @(negedge clk);
    do_reset();
    // Frame A5
    slot(MK, 40); slot(hi_slot(10), 40); slot(lo_slot(5), 40);
    // Glitch inside the high slot
    slot(MK, 40); slot(hi_slot(10), 5); slot({3'b100, 8'h00}, 10);
    slot(hi_slot(10), 40); slot(lo_slot(5), 40);
    // Invalid high pattern, then 3C
    slot(MK, 40); slot({3'b100, 8'hFF}, 40);
    slot(MK, 40); slot(hi_slot(3), 40); slot(lo_slot(12), 40);
    // Out-of-order marker, then 27
    slot(MK, 40); slot(hi_slot(1), 40); slot(MK, 40);
    slot(hi_slot(2), 40); slot(lo_slot(7), 40);
    // Stale timeout after 5A
    slot(MK, 40); slot(hi_slot(5), 40); slot(lo_slot(10), 40); slot(11'h000, 260);
    // Reset mid-frame, then orphan low slot
    slot(MK, 40); slot(hi_slot(1), 40);
    do_reset();
    slot(lo_slot(2), 40);
    // Randomized slot streams
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      v = MK;
      else if (r < 45) v = hi_slot($urandom_range(0, 15));
      else if (r < 65) v = lo_slot($urandom_range(0, 15));
      else if (r < 75) v = {3'b000, 8'($urandom)};
      else if (r < 85) v = {3'($urandom_range(0, 7)), 8'($urandom)};
      else             v = {($urandom_range(0, 1) != 0) ? 3'b100 : 3'b010, 8'($urandom)};
      if (v == prev_run) continue;
      r = $urandom_range(0, 99);
      if (r < 12)      d = $urandom_range(1, SETTLE - 2);
      else if (r < 24) d = $urandom_range(SETTLE - 1, SETTLE + 2);
      else if (r < 27) d = $urandom_range(190, 240);
      else             d = $urandom_range(SETTLE + 3, SETTLE + 40);
      slot(v, d);
    end
    slot(11'h000, LAT + 10);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
